// File: rtl/msrv32_fetch_ctrl_if.sv
// Instruction-memory request bus between the fetch controller and instruction memory.
// The fetch controller is the master; the memory is the slave.
interface msrv32_fetch_ctrl_if;
    logic [31:0] imaddr_out;
    logic        imreq_out;
    logic        imrdy_in;
    logic [31:0] imdata_in;

    modport master (
        output imaddr_out,
        output imreq_out,
        input  imrdy_in,
        input  imdata_in
    );

    modport slave (
        input  imaddr_out,
        input  imreq_out,
        output imrdy_in,
        output imdata_in
    );
endinterface

// File: rtl/msrv32_fetch_ctrl.sv
// Instruction fetch sequencer for the RV32I core: one outstanding word request,
// stall hold, redirect flush/drain and a fetch-timeout bus error pulse.
module msrv32_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDRESS   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                       ms_riscv32_mp_clk_in,
    input  logic                       ms_riscv32_mp_rst_in,
    input  logic [31:0]                pc_in,
    input  logic                       branch_taken_in,
    input  logic                       trap_taken_in,
    input  logic                       stall_in,
    msrv32_fetch_ctrl_if.master        imem,
    output logic [31:0]                instr_out,
    output logic                       instr_valid_out,
    output logic                       flush_out,
    output logic                       bus_err_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] BOOT_ALIGNED = BOOT_ADDRESS & 32'hFFFF_FFFC;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [31:0] imaddr_reg, imaddr_next;
    logic        imreq_reg, imreq_next;
    logic [31:0] instr_reg, instr_next;
    logic        instr_valid_reg, instr_valid_next;
    logic        flush_reg, flush_next;
    logic        bus_err_reg, bus_err_next;
    logic [15:0] tcount_reg, tcount_next;
    logic [31:0] redir_pc_reg, redir_pc_next;

    logic        redirect;
    logic [31:0] pc_aligned;
    logic [15:0] tcount_inc;

    assign redirect   = branch_taken_in | trap_taken_in;
    assign pc_aligned = pc_in & 32'hFFFF_FFFC;
    assign tcount_inc = tcount_reg + 16'd1;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_reg       <= IDLE;
            imaddr_reg      <= BOOT_ALIGNED;
            imreq_reg       <= 1'b0;
            instr_reg       <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
            flush_reg       <= 1'b1;
            bus_err_reg     <= 1'b0;
            tcount_reg      <= 16'd0;
            redir_pc_reg    <= BOOT_ALIGNED;
        end else begin
            state_reg       <= state_next;
            imaddr_reg      <= imaddr_next;
            imreq_reg       <= imreq_next;
            instr_reg       <= instr_next;
            instr_valid_reg <= instr_valid_next;
            flush_reg       <= flush_next;
            bus_err_reg     <= bus_err_next;
            tcount_reg      <= tcount_next;
            redir_pc_reg    <= redir_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        imaddr_next      = imaddr_reg;
        imreq_next       = imreq_reg;
        instr_next       = instr_reg;
        instr_valid_next = instr_valid_reg;
        flush_next       = flush_reg;
        redir_pc_next    = redir_pc_reg;

        case (state_reg)
            IDLE: begin
                state_next  = FETCH;
                imaddr_next = BOOT_ALIGNED;
                imreq_next  = 1'b1;
            end
            FETCH: begin
                if (redirect) begin
                    redir_pc_next    = pc_aligned;
                    instr_next       = NOP_INSTR;
                    instr_valid_next = 1'b0;
                    flush_next       = 1'b1;
                    if (imem.imrdy_in) begin
                        // Current word is stale; relaunch immediately at the target.
                        state_next  = FETCH;
                        imaddr_next = pc_aligned;
                        imreq_next  = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (imem.imrdy_in) begin
                    instr_next       = imem.imdata_in;
                    instr_valid_next = 1'b1;
                    flush_next       = 1'b0;
                    imreq_next       = 1'b0;
                    state_next       = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    redir_pc_next    = pc_aligned;
                    instr_next       = NOP_INSTR;
                    instr_valid_next = 1'b0;
                    flush_next       = 1'b1;
                    state_next       = FETCH;
                    imaddr_next      = pc_aligned;
                    imreq_next       = 1'b1;
                end else if (!stall_in) begin
                    imaddr_next      = pc_aligned;
                    imreq_next       = 1'b1;
                    instr_valid_next = 1'b0;
                    state_next       = FETCH;
                end
            end
            DRAIN: begin
                // The outstanding request cannot be retracted; wait for it, then drop its data.
                if (redirect) begin
                    redir_pc_next = pc_aligned;
                    if (imem.imrdy_in) begin
                        state_next  = FETCH;
                        imaddr_next = pc_aligned;
                        imreq_next  = 1'b1;
                    end
                end else if (imem.imrdy_in) begin
                    state_next  = FETCH;
                    imaddr_next = redir_pc_reg;
                    imreq_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        tcount_next  = tcount_reg;
        bus_err_next = 1'b0;
        if (imem.imrdy_in ||
            ((state_next != state_reg) && ((state_next == FETCH) || (state_next == DRAIN)))) begin
            tcount_next = 16'd0;
        end else if (imreq_reg) begin
            if (tcount_inc >= TIMEOUT_LAST) begin
                tcount_next  = 16'd0;
                bus_err_next = 1'b1;
            end else begin
                tcount_next = tcount_inc;
            end
        end
    end

    assign imem.imaddr_out = imaddr_reg;
    assign imem.imreq_out  = imreq_reg;
    assign instr_out       = instr_reg;
    assign instr_valid_out = instr_valid_reg;
    assign flush_out       = flush_reg;
    assign bus_err_out     = bus_err_reg;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Directed vector bench for msrv32_fetch_ctrl: a cycle-by-cycle table of
// inputs and expected registered outputs, plus a long fetch-timeout sequence.
module tb_msrv32_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NVEC = 31;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic        branch_taken_in = 1'b0;
    logic        trap_taken_in = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] instr_out;
    logic        instr_valid_out;
    logic        flush_out;
    logic        bus_err_out;

    int tests = 0;
    int fails = 0;

    msrv32_fetch_ctrl_if imem_bus ();

    msrv32_fetch_ctrl #(
        .BOOT_ADDRESS   (32'h0000_0000),
        .NOP_INSTR      (NOP),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (srst),
        .pc_in                (pc_in),
        .branch_taken_in      (branch_taken_in),
        .trap_taken_in        (trap_taken_in),
        .stall_in             (stall_in),
        .imem                 (imem_bus),
        .instr_out            (instr_out),
        .instr_valid_out      (instr_valid_out),
        .flush_out            (flush_out),
        .bus_err_out          (bus_err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        br;
        logic        tr;
        logic        st;
        logic        rdy;
        logic [31:0] data;
        logic [31:0] e_addr;
        logic        e_req;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_flush;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic br,
                                input logic tr, input logic st, input logic rdy,
                                input logic [31:0] d, input logic [31:0] ea, input logic er,
                                input logic [31:0] ei, input logic ev, input logic ef);
        vec_t v;
        v.rst = r;  v.pc = pc;  v.br = br;  v.tr = tr;  v.st = st;  v.rdy = rdy;  v.data = d;
        v.e_addr = ea;  v.e_req = er;  v.e_instr = ei;  v.e_valid = ev;  v.e_flush = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic br, input logic tr,
                         input logic st, input logic rdy, input logic [31:0] d);
        srst               = r;
        pc_in              = pc;
        branch_taken_in    = br;
        trap_taken_in      = tr;
        stall_in           = st;
        imem_bus.imrdy_in  = rdy;
        imem_bus.imdata_in = d;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int pulse_at;
        int req_drops;

        imem_bus.imrdy_in  = 1'b0;
        imem_bus.imdata_in = 32'h0;

        //            rst pc            br tr st rdy data           addr          req instr          v  f
        vecs[0]  = mk(1, 32'h0,        0, 0, 0, 1, 32'h12345678, 32'h0,        0, NOP,           0, 1);
        vecs[1]  = mk(1, 32'h0,        0, 0, 0, 1, 32'h12345678, 32'h0,        0, NOP,           0, 1);
        vecs[2]  = mk(1, 32'h0,        0, 0, 0, 1, 32'h12345678, 32'h0,        0, NOP,           0, 1);
        vecs[3]  = mk(0, 32'h0,        0, 0, 0, 1, 32'h12345678, 32'h0,        1, NOP,           0, 1);
        vecs[4]  = mk(0, 32'h0,        0, 0, 0, 1, 32'h12345678, 32'h0,        0, 32'h12345678,  1, 0);
        vecs[5]  = mk(0, 32'h8,        0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h12345678,  1, 0);
        vecs[6]  = mk(0, 32'h8,        0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h12345678,  1, 0);
        vecs[7]  = mk(0, 32'h8,        0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h12345678,  1, 0);
        vecs[8]  = mk(0, 32'h8,        0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h12345678,  1, 0);
        vecs[9]  = mk(0, 32'h8,        0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h12345678,  1, 0);
        vecs[10] = mk(0, 32'h8,        0, 0, 0, 0, 32'h0,        32'h8,        1, 32'h12345678,  0, 0);
        vecs[11] = mk(0, 32'h8,        0, 0, 0, 1, 32'hAAAA0001, 32'h8,        0, 32'hAAAA0001,  1, 0);
        vecs[12] = mk(0, 32'h10,       0, 0, 0, 0, 32'h0,        32'h10,       1, 32'hAAAA0001,  0, 0);
        vecs[13] = mk(0, 32'h100,      1, 0, 0, 0, 32'h0,        32'h10,       1, NOP,           0, 1);
        vecs[14] = mk(0, 32'h55,       0, 0, 0, 0, 32'h0,        32'h10,       1, NOP,           0, 1);
        vecs[15] = mk(0, 32'h44,       0, 0, 0, 1, 32'hDEADBEEF, 32'h100,      1, NOP,           0, 1);
        vecs[16] = mk(0, 32'h0,        0, 0, 0, 1, 32'hBBBB0002, 32'h100,      0, 32'hBBBB0002,  1, 0);
        vecs[17] = mk(0, 32'h104,      0, 0, 0, 0, 32'h0,        32'h104,      1, 32'hBBBB0002,  0, 0);
        vecs[18] = mk(0, 32'h1C0,      0, 1, 0, 1, 32'hCCCC0003, 32'h1C0,      1, NOP,           0, 1);
        vecs[19] = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h1C0,      1, NOP,           0, 1);
        vecs[20] = mk(0, 32'h0,        0, 0, 0, 1, 32'hDDDD0004, 32'h1C0,      0, 32'hDDDD0004,  1, 0);
        vecs[21] = mk(0, 32'h203,      1, 0, 1, 0, 32'h0,        32'h200,      1, NOP,           0, 1);
        vecs[22] = mk(0, 32'h300,      1, 0, 0, 0, 32'h0,        32'h200,      1, NOP,           0, 1);
        vecs[23] = mk(0, 32'h400,      0, 1, 0, 0, 32'h0,        32'h200,      1, NOP,           0, 1);
        vecs[24] = mk(0, 32'h0,        0, 0, 0, 1, 32'hEEEE0000, 32'h400,      1, NOP,           0, 1);
        vecs[25] = mk(0, 32'h0,        0, 0, 0, 1, 32'h0000F00D, 32'h400,      0, 32'h0000F00D,  1, 0);
        vecs[26] = mk(0, 32'h404,      0, 0, 0, 0, 32'h0,        32'h404,      1, 32'h0000F00D,  0, 0);
        vecs[27] = mk(0, 32'h500,      1, 0, 0, 0, 32'h0,        32'h404,      1, NOP,           0, 1);
        vecs[28] = mk(1, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, NOP,           0, 1);
        vecs[29] = mk(0, 32'h600,      1, 0, 0, 0, 32'h0,        32'h0,        1, NOP,           0, 1);
        vecs[30] = mk(0, 32'h0,        0, 0, 0, 1, 32'h11110005, 32'h0,        0, 32'h11110005,  1, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].pc, vecs[i].br, vecs[i].tr, vecs[i].st,
                  vecs[i].rdy, vecs[i].data);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d imaddr", i), imem_bus.imaddr_out, vecs[i].e_addr);
            check($sformatf("vec%0d imreq", i), 32'(imem_bus.imreq_out), 32'(vecs[i].e_req));
            check($sformatf("vec%0d instr", i), instr_out, vecs[i].e_instr);
            check($sformatf("vec%0d valid", i), 32'(instr_valid_out), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d flush", i), 32'(flush_out), 32'(vecs[i].e_flush));
            check($sformatf("vec%0d bus_err", i), 32'(bus_err_out), 32'h0);
            $display("[TB] vec %0d rst=%0b pc=%h br=%0b tr=%0b st=%0b rdy=%0b -> addr=%h req=%0b instr=%h v=%0b f=%0b",
                     i, vecs[i].rst, vecs[i].pc, vecs[i].br, vecs[i].tr, vecs[i].st, vecs[i].rdy,
                     imem_bus.imaddr_out, imem_bus.imreq_out, instr_out, instr_valid_out, flush_out);
        end

        // Fetch timeout: launch a fetch at 0x800 and withhold imrdy_in for 300 cycles.
        drive(0, 32'h800, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        check("timeout launch imaddr", imem_bus.imaddr_out, 32'h800);
        pulses    = 0;
        pulse_at  = 0;
        req_drops = 0;
        for (int k = 1; k <= 300; k++) begin
            if (bus_err_out) begin
                pulses++;
                if (pulse_at == 0) pulse_at = k;
            end
            if (!imem_bus.imreq_out) req_drops++;
            @(posedge clk);
            #1;
        end
        check("timeout pulse count", 32'(pulses), 32'd1);
        check("timeout pulse cycle", 32'(pulse_at), 32'd255);
        check("timeout imreq drops", 32'(req_drops), 32'd0);
        check("timeout imaddr held", imem_bus.imaddr_out, 32'h800);
        $display("[TB] timeout wait: pulses=%0d first_at=%0d req_drops=%0d", pulses, pulse_at, req_drops);

        drive(0, 32'h0, 0, 0, 0, 1, 32'h22220006);
        @(posedge clk);
        #1;
        check("post-timeout instr", instr_out, 32'h22220006);
        check("post-timeout valid", 32'(instr_valid_out), 32'h1);
        check("post-timeout bus_err", 32'(bus_err_out), 32'h0);
        $display("[TB] post-timeout capture: instr=%h v=%0b", instr_out, instr_valid_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
